// File: rtl/mire_pkg.sv
// Shared types and colour constants for the mire_multi test-image generator.
package mire_pkg;

  typedef enum logic [1:0] {
    MODE_GRID  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_BLACK   = 24'h000000;

  // Index 0 is the leftmost bar.
  localparam logic [7:0][23:0] BAR_COLORS = {
    C_BLACK, C_BLUE, C_RED, C_MAGENTA, C_GREEN, C_CYAN, C_YELLOW, C_WHITE
  };

endpackage

// File: rtl/wshb_if.sv
// Wishbone bus interface with clock and synchronous active-high reset.
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  modport master (
    input  clk, rst, ack, dat_sm,
    output cyc, stb, we, adr, dat_ms, sel, cti, bte
  );

  modport slave (
    input  clk, rst, cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output ack, dat_sm
  );
endinterface

// File: rtl/mire_pattern.sv
// Combinational pixel generator: (p, l, mode, color) -> 32-bit 0x00RRGGBB pixel.
module mire_pattern
  import mire_pkg::*;
#(
  parameter int unsigned HDISP     = 800,
  parameter int unsigned GRID_STEP = 16,
  parameter int unsigned PW        = 10,
  parameter int unsigned LW        = 9
) (
  input  logic [PW-1:0] i_p,
  input  logic [LW-1:0] i_l,
  input  mode_t         i_mode,
  input  logic [23:0]   i_color,
  output logic [31:0]   o_pixel
);

  logic [31:0] w_p;
  logic [31:0] w_l;
  logic [2:0]  w_bar;
  logic [23:0] w_rgb;

  always_comb begin
    w_p   = 32'(i_p);
    w_l   = 32'(i_l);
    w_bar = 3'(w_p / (HDISP / 8));
    w_rgb = C_BLACK;
    unique case (i_mode)
      MODE_GRID: begin
        if (((w_p % GRID_STEP) == 32'd0) || ((w_l % GRID_STEP) == 32'd0)) w_rgb = C_WHITE;
      end
      MODE_BARS:  w_rgb = BAR_COLORS[w_bar];
      MODE_CHECK: begin
        if ((((w_p / GRID_STEP) ^ (w_l / GRID_STEP)) & 32'd1) == 32'd0) w_rgb = C_WHITE;
      end
      MODE_SOLID: w_rgb = i_color;
      default:    w_rgb = C_BLACK;
    endcase
    o_pixel = {8'h00, w_rgb};
  end

endmodule

// File: rtl/mire_multi.sv
// Multi-pattern test-image Wishbone master writing one frame per request or continuously.
// Define MIRE_BURST_EN to tag beats as incrementing bursts (cti 010, last beat 111).
module mire_multi
  import mire_pkg::*;
#(
  parameter int unsigned HDISP     = 800,
  parameter int unsigned VDISP     = 480,
  parameter logic [31:0] BASE_ADR  = 32'h0,
  parameter int unsigned BURST_LEN = 64,
  parameter int unsigned GRID_STEP = 16
) (
  wshb_if.master        wshb_ifm,
  input  logic [1:0]    mode,
  input  logic [23:0]   color,
  input  logic          start,
  input  logic          free_run,
  output logic          busy,
  output logic          frame_done
);

  localparam int unsigned PW = $clog2(HDISP);
  localparam int unsigned LW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_t        r_state;
  mode_t         r_mode;
  logic [23:0]   r_color;
  logic [PW-1:0] r_pixel_cpt;
  logic [LW-1:0] r_line_cpt;
  logic [BW-1:0] r_burst_cpt;
  logic          r_frame_end;
  logic          r_cyc, r_stb, r_busy, r_frame_done;
  logic [31:0]   r_adr, r_dat;
  logic [2:0]    r_cti;

  logic          w_ack, w_adv, w_pix_last, w_beat_last, w_restart, w_nxt_last;
  logic [PW-1:0] w_p_nxt;
  logic [LW-1:0] w_l_nxt;
  logic [BW-1:0] w_b_nxt;
  mode_t         w_mode;
  logic [23:0]   w_color;
  logic [31:0]   w_pixel, w_adr_nxt;
  logic [2:0]    w_cti_nxt;
  logic          w_unused;

  assign w_unused    = ^wshb_ifm.dat_sm;
  assign w_ack       = wshb_ifm.ack;
  assign w_adv       = (r_state == BURST) && w_ack;
  assign w_pix_last  = (r_pixel_cpt == PW'(HDISP - 1)) && (r_line_cpt == LW'(VDISP - 1));
  assign w_beat_last = (r_burst_cpt == BW'(BURST_LEN - 1)) || w_pix_last;
  assign w_restart   = ((r_state == IDLE) && (start || free_run)) ||
                       ((r_state == GAP) && r_frame_end && free_run);

  // Counter values for the next cycle; the register stage presents the pixel they address.
  always_comb begin
    w_p_nxt = r_pixel_cpt;
    w_l_nxt = r_line_cpt;
    w_b_nxt = r_burst_cpt;
    w_mode  = r_mode;
    w_color = r_color;
    if (w_restart) begin
      w_p_nxt = '0;
      w_l_nxt = '0;
      w_b_nxt = '0;
      w_mode  = mode_t'(mode);
      w_color = color;
    end else if (r_state == GAP) begin
      w_b_nxt = '0;
    end else if (w_adv) begin
      if (r_pixel_cpt == PW'(HDISP - 1)) begin
        w_p_nxt = '0;
        w_l_nxt = (r_line_cpt == LW'(VDISP - 1)) ? '0 : r_line_cpt + 1'b1;
      end else begin
        w_p_nxt = r_pixel_cpt + 1'b1;
      end
      w_b_nxt = w_beat_last ? '0 : r_burst_cpt + 1'b1;
    end
  end

  assign w_adr_nxt  = BASE_ADR + ((32'(w_l_nxt) * HDISP + 32'(w_p_nxt)) << 2);
  assign w_nxt_last = (w_b_nxt == BW'(BURST_LEN - 1)) ||
                      ((w_p_nxt == PW'(HDISP - 1)) && (w_l_nxt == LW'(VDISP - 1)));

`ifdef MIRE_BURST_EN
  assign w_cti_nxt = w_nxt_last ? 3'b111 : 3'b010;
`else
  assign w_cti_nxt = w_nxt_last ? 3'b000 : 3'b000;
`endif

  mire_pattern #(
    .HDISP     (HDISP),
    .GRID_STEP (GRID_STEP),
    .PW        (PW),
    .LW        (LW)
  ) u_pattern (
    .i_p     (w_p_nxt),
    .i_l     (w_l_nxt),
    .i_mode  (w_mode),
    .i_color (w_color),
    .o_pixel (w_pixel)
  );

  always_ff @(posedge wshb_ifm.clk) begin
    if (wshb_ifm.rst) begin
      r_state      <= IDLE;
      r_mode       <= MODE_GRID;
      r_color      <= '0;
      r_pixel_cpt  <= '0;
      r_line_cpt   <= '0;
      r_burst_cpt  <= '0;
      r_frame_end  <= 1'b0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_adr        <= BASE_ADR;
      r_dat        <= '0;
      r_cti        <= 3'b000;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_pixel_cpt  <= w_p_nxt;
      r_line_cpt   <= w_l_nxt;
      r_burst_cpt  <= w_b_nxt;
      r_mode       <= w_mode;
      r_color      <= w_color;
      unique case (r_state)
        IDLE: begin
          if (w_restart) begin
            r_state     <= BURST;
            r_cyc       <= 1'b1;
            r_stb       <= 1'b1;
            r_busy      <= 1'b1;
            r_frame_end <= 1'b0;
            r_adr       <= w_adr_nxt;
            r_dat       <= w_pixel;
            r_cti       <= w_cti_nxt;
          end
        end
        BURST: begin
          if (w_ack) begin
            r_adr <= w_adr_nxt;
            r_dat <= w_pixel;
            r_cti <= w_cti_nxt;
            if (w_beat_last) begin
              r_state      <= GAP;
              r_cyc        <= 1'b0;
              r_stb        <= 1'b0;
              r_frame_end  <= w_pix_last;
              r_frame_done <= w_pix_last;
            end
          end
        end
        GAP: begin
          r_adr <= w_adr_nxt;
          r_dat <= w_pixel;
          r_cti <= w_cti_nxt;
          if (!r_frame_end || free_run) begin
            r_state     <= BURST;
            r_cyc       <= 1'b1;
            r_stb       <= 1'b1;
            r_frame_end <= 1'b0;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wshb_ifm.cyc    = r_cyc;
  assign wshb_ifm.stb    = r_stb;
  assign wshb_ifm.we     = 1'b1;
  assign wshb_ifm.sel    = 4'hF;
  assign wshb_ifm.bte    = 2'b00;
  assign wshb_ifm.adr    = r_adr;
  assign wshb_ifm.dat_ms = r_dat;
  assign wshb_ifm.cti    = r_cti;
  assign busy            = r_busy;
  assign frame_done      = r_frame_done;

endmodule

// File: tb/tb_mire_multi.sv
// Self-checking bench for mire_multi: frame model plus directed pattern, stall, free-run and reset cases.
module tb_mire_multi;

  localparam int HD = 32, VD = 4, BL = 8, GS = 4, NPIX = HD * VD;
  localparam logic [31:0] BASE = 32'h1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  mode = 2'd0;
  logic [23:0] color = 24'h0;
  logic        start = 1'b0, free_run = 1'b0;
  logic        busy, frame_done;
  logic        ack_v = 1'b0;

  wshb_if wshb (.clk(clk), .rst(rst));
  assign wshb.dat_sm = 32'h0;
  assign wshb.ack    = ack_v;

  mire_multi #(
    .HDISP(HD), .VDISP(VD), .BASE_ADR(BASE), .BURST_LEN(BL), .GRID_STEP(GS)
  ) dut (
    .wshb_ifm(wshb), .mode(mode), .color(color), .start(start), .free_run(free_run),
    .busy(busy), .frame_done(frame_done)
  );

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] golden(input int p, input int l, input int m,
                                         input logic [23:0] c);
    int b;
    case (m)
      0: return ((p % GS == 0) || (l % GS == 0)) ? 32'h00FFFFFF : 32'h0;
      1: begin
        b = p / (HD / 8);
        case (b)
          0: return 32'h00FFFFFF;
          1: return 32'h00FFFF00;
          2: return 32'h0000FFFF;
          3: return 32'h0000FF00;
          4: return 32'h00FF00FF;
          5: return 32'h00FF0000;
          6: return 32'h000000FF;
          default: return 32'h0;
        endcase
      end
      2: return ((((p / GS) ^ (l / GS)) & 1) == 0) ? 32'h00FFFFFF : 32'h0;
      default: return {8'h00, c};
    endcase
  endfunction

  // Frame model state, advanced once per accepted write.
  int k = 0, bk = 0, gap_chk = 0, cyc_n = 0, first_cyc = 0, last_cyc = 0;
  int exp_mode = 0, fd_cnt = 0, stall_checks = 0, stall_cnt = 0;
  logic [23:0] exp_color = 24'h0;
  logic        fr_end_pend = 1'b0, more_exp = 1'b0, prev_stall = 1'b0, ack_rand = 1'b0;
  logic [31:0] prev_adr = 32'h0, prev_dat = 32'h0, last_adr = 32'h0;
  logic [31:0] img [NPIX];

  always @(negedge clk) begin
    cyc_n++;
    if (rst) begin
      k = 0; bk = 0; gap_chk = 0; prev_stall = 1'b0; fr_end_pend = 1'b0;
    end else begin
      if (frame_done) fd_cnt++;
      if (gap_chk == 2) begin
        check("gap_cyc_low", 32'(wshb.cyc), 32'd0);
        if (fr_end_pend) check("frame_done_in_gap", 32'(frame_done), 32'd1);
        more_exp = !fr_end_pend || free_run;
        gap_chk  = 1;
      end else if (gap_chk == 1) begin
        if (more_exp) check("cyc_reassert", 32'(wshb.cyc), 32'd1);
        else          check("busy_low_after_frame", 32'(busy), 32'd0);
        fr_end_pend = 1'b0;
        gap_chk     = 0;
      end
      if (prev_stall && wshb.stb) begin
        stall_checks++;
        check("stall_adr_hold", wshb.adr, prev_adr);
        check("stall_dat_hold", wshb.dat_ms, prev_dat);
      end
      if (ack_rand) begin
        if (stall_cnt > 0) begin ack_v = 1'b0; stall_cnt--; end
        else begin ack_v = 1'b1; stall_cnt = $urandom_range(0, 5); end
      end else begin
        ack_v = 1'b1;
      end
      if (wshb.cyc && wshb.stb && ack_v) begin
        if (k == 0) begin exp_mode = int'(mode); exp_color = color; first_cyc = cyc_n; end
        check("adr", wshb.adr, BASE + 32'(4 * k));
        check("dat", wshb.dat_ms, golden(k % HD, k / HD, exp_mode, exp_color));
`ifdef MIRE_BURST_EN
        check("cti", 32'(wshb.cti), (bk == BL - 1 || k == NPIX - 1) ? 32'd7 : 32'd2);
`else
        check("cti", 32'(wshb.cti), 32'd0);
`endif
        img[k]   = wshb.dat_ms;
        last_adr = wshb.adr;
        if (bk == BL - 1 || k == NPIX - 1) begin
          gap_chk = 2; bk = 0; fr_end_pend = (k == NPIX - 1);
        end else begin
          bk++;
        end
        if (k == NPIX - 1) begin last_cyc = cyc_n; k = 0; end
        else k++;
      end
      prev_stall = wshb.stb && !ack_v;
      prev_adr   = wshb.adr;
      prev_dat   = wshb.dat_ms;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("start_cyc", 32'(wshb.cyc), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_adr", wshb.adr, BASE);
  endtask

  task automatic wait_done(input int budget);
    int f0 = fd_cnt;
    int n = 0;
    while (fd_cnt == f0 && n < budget) begin tick(1); n++; end
    check("frame_done_timeout", 32'(fd_cnt != f0), 32'd1);
  endtask

  task automatic wait_writes(input int target, input int budget);
    int n = 0;
    while (k < target && n < budget) begin tick(1); n++; end
    check("write_wait_timeout", 32'(k >= target), 32'd1);
  endtask

  int fd0;

  initial begin
    tick(3);
    rst = 1'b0;
    check("rst_cyc", 32'(wshb.cyc), 32'd0);
    check("rst_stb", 32'(wshb.stb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_adr", wshb.adr, BASE);
    check("rst_dat", wshb.dat_ms, 32'h0);
    check("rst_cti", 32'(wshb.cti), 32'd0);
    check("rst_we_sel_bte", {27'd0, wshb.we, wshb.sel}, 32'h1F);
    tick(2);

    // Grid, ack always high
    mode = 2'd0;
    pulse_start();
    wait_done(1000);
    check("grid_p1_1", img[1 * HD + 1], 32'h0);
    check("grid_p4_1", img[1 * HD + 4], 32'h00FFFFFF);
    check("grid_last_adr", last_adr, 32'h11FC);
    check("grid_cycles", 32'(last_cyc - first_cyc), 32'd142);
    tick(10);
    check("grid_one_done", 32'(fd_cnt), 32'd1);
    check("grid_idle", 32'(busy), 32'd0);

    // Colour bars
    mode = 2'd1;
    pulse_start();
    wait_done(1000);
    for (int i = 0; i < 4; i++) begin
      check("bars_white", img[i], 32'h00FFFFFF);
      check("bars_yellow", img[4 + i], 32'h00FFFF00);
      check("bars_black", img[28 + i], 32'h0);
    end
    tick(5);

    // Checker with random ack stalls
    mode = 2'd2;
    ack_rand = 1'b1;
    pulse_start();
    wait_done(6000);
    ack_rand = 1'b0;
    check("stall_seen", 32'(stall_checks > 0), 32'd1);
    check("check_p0", img[0], 32'h00FFFFFF);
    check("check_p4", img[4], 32'h0);
    check("check_p8", img[8], 32'h00FFFFFF);
    tick(5);

    // Free run: solid frame then checker frame
    fd0 = fd_cnt;
    mode = 2'd3;
    color = 24'h123456;
    free_run = 1'b1;
    wait_writes(60, 1000);
    mode = 2'd2;
    wait_done(1000);
    check("fr_solid_first", img[0], 32'h00123456);
    check("fr_solid_last", img[NPIX - 1], 32'h00123456);
    wait_writes(10, 1000);
    free_run = 1'b0;
    wait_done(1000);
    check("fr_check_p4", img[4], 32'h0);
    check("fr_check_p127", img[NPIX - 1], 32'h0);
    tick(5);
    check("fr_two_done", 32'(fd_cnt - fd0), 32'd2);
    check("fr_idle", 32'(busy), 32'd0);

    // Reset mid-frame
    fd0 = fd_cnt;
    mode = 2'd0;
    pulse_start();
    wait_writes(50, 1000);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_cyc", 32'(wshb.cyc), 32'd0);
    check("midrst_stb", 32'(wshb.stb), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    tick(20);
    check("midrst_no_done", 32'(fd_cnt - fd0), 32'd0);
    pulse_start();
    wait_done(1000);
    check("midrst_restart_done", 32'(fd_cnt - fd0), 32'd1);
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
